// File: rtl/instruction_fetch_unit.sv
// IF stage: owns the PC, addresses the combinational instruction ROM and fills the IF/ID register.
// Optional IFU_PERF_CNT_EN adds fetch_count/stall_count performance counters.
`default_nettype none

module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          PC_STEP  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        flush,
  input  logic        branch_taken,
  input  logic [31:0] branch_addr,
  output logic [31:0] imem_pc,
  input  logic [31:0] imem_inst,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_inst,
  output logic        if_id_valid
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [31:0] fetch_count,
  output logic [31:0] stall_count
`endif
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    STALL = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] pc_seq;

  assign imem_pc = pc;
  assign pc_seq  = pc + 32'(PC_STEP);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= BOOT;
      pc          <= RESET_PC;
      if_id_pc    <= 32'h0;
      if_id_inst  <= 32'h0;
      if_id_valid <= 1'b0;
`ifdef IFU_PERF_CNT_EN
      fetch_count <= 32'h0;
      stall_count <= 32'h0;
`endif
    end else if (state == BOOT) begin
      // One settling cycle: PC held and IF/ID stays a bubble.
      state <= RUN;
    end else begin
      if (branch_taken) begin
        pc    <= {branch_addr[31:2], 2'b00};
        state <= RUN;
      end else if (freeze) begin
        state <= STALL;
      end else begin
        pc    <= pc_seq;
        state <= RUN;
      end

      // A redirect squashes the word fetched this cycle, even under freeze.
      if (flush || branch_taken) begin
        if_id_pc    <= 32'h0;
        if_id_inst  <= 32'h0;
        if_id_valid <= 1'b0;
      end else if (!freeze) begin
        if_id_pc    <= pc_seq;
        if_id_inst  <= imem_inst;
        if_id_valid <= 1'b1;
`ifdef IFU_PERF_CNT_EN
        fetch_count <= fetch_count + 32'd1;
`endif
      end

`ifdef IFU_PERF_CNT_EN
      if (state == STALL) begin
        stall_count <= stall_count + 32'd1;
      end
`endif
    end
  end

endmodule

`default_nettype wire
